seq_alu: RTL



---
 rtl/seq_alu_pkg.sv | 15 +
 rtl/seq_alu_shift_add_mul.sv | 73 +++++++
 rtl/seq_alu.sv | 136 +++++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcode and FSM state definitions for seq_alu.
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_alu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, fixed
// WIDTH-cycle latency after start, with a 1-cycle done pulse.
module shift_add_mul #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               run_q, run_d;
    logic               done_q, done_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        done_d   = 1'b0;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            // Runs all WIDTH iterations even for zero operands so latency is fixed
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            done_q   <= done_d;
        end
    end

    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/seq_alu.sv
// Registered select-ALU with valid/ready handshakes and iterative multiply.
// Optional SEQ_ALU_OP_CNT_EN adds a saturating output-handshake counter (op_count).
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned DEFAULT_VAL = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         select,
    input  logic [WIDTH-1:0]   X,
    input  logic [WIDTH-1:0]   Y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               busy
`ifdef SEQ_ALU_OP_CNT_EN
    ,
    output logic [15:0]        op_count
`endif
);

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] alu_res;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign accept    = in_valid && (state_q == S_IDLE);
    assign mul_start = accept && (select == OP_MUL);

    shift_add_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (X),
        .b       (Y),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        alu_res = '0;
        case (select)
            OP_ADD:  alu_res = (2*WIDTH)'(X) + (2*WIDTH)'(Y);
            OP_AND:  alu_res = {{WIDTH{1'b1}}, X & Y};
            OP_MUL:  alu_res = '0;
            OP_SUB:  alu_res = (2*WIDTH)'(X) - (2*WIDTH)'(Y);
            default: alu_res = (2*WIDTH)'(DEFAULT_VAL);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (select == OP_MUL) begin
                        state_d = S_BUSY;
                    end else begin
                        state_d     = S_DONE;
                        out_d       = alu_res;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (mul_done) begin
                    state_d     = S_DONE;
                    out_d       = mul_product;
                    out_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out       = out_q;
    // Drops in the cycle the product is final, while the FSM latches it into out
    assign busy      = (state_q == S_BUSY) && !mul_done;

`ifdef SEQ_ALU_OP_CNT_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (out_valid_q && out_ready && (op_count_q != 16'hFFFF)) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule
